// File: rtl/store_sequencer.sv
// Store sequencer: drives the data memory for word stores directly and for
// half/byte stores by read, latency wait, low-lane merge and write-back.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start; operands are latched on acceptance
// READ    | read address presented, no write
// WAIT    | counting out MEM_LAT cycles; merge captured on the last one
// WRITE   | mem_wr high for exactly one cycle
// DONE    | done pulse
// EXC     | exc pulse, request rejected without a memory write
module store_sequencer #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  store_size,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr,
    output logic        busy,
    output logic        done,
    output logic        exc
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_EXC   = 3'd5;

    localparam logic [1:0] SZ_WORD = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    logic [2:0]  state;
    logic [2:0]  wait_cnt;
    logic [15:0] data_q;
    logic [1:0]  size_q;
    logic        reject;

    always_comb begin
        reject = (store_size == 2'b00)
              || ((store_size == SZ_HALF) && addr[0])
              || ((store_size == SZ_WORD) && (addr[1:0] != 2'b00));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            wait_cnt  <= 3'd0;
            data_q    <= 16'd0;
            size_q    <= 2'b00;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        data_q   <= store_data[15:0];
                        size_q   <= store_size;
                        mem_addr <= addr;
                        if (reject) begin
                            state <= S_EXC;
                        end else if (store_size == SZ_WORD) begin
                            mem_wdata <= store_data;
                            state     <= S_WRITE;
                        end else begin
                            state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    wait_cnt <= LAT;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    // Read data is valid on the last wait cycle; merge lanes are always the low bits.
                    if (wait_cnt <= 3'd1) begin
                        if (size_q == SZ_HALF)
                            mem_wdata <= {mem_rdata[31:16], data_q};
                        else
                            mem_wdata <= {mem_rdata[31:8], data_q[7:0]};
                        state <= S_WRITE;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                S_WRITE: state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mem_wr = (state == S_WRITE);
    assign busy   = (state != S_IDLE);
    assign done   = (state == S_DONE);
    assign exc    = (state == S_EXC);

endmodule

// File: tb/tb_store_sequencer.sv
// Directed bench for store_sequencer: two instances (MEM_LAT=1 and 3) share
// the stimulus; each scenario observes the instance it targets.
module tb_store_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  store_size;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] mem_rdata;

    logic [31:0] mem_addr1, mem_wdata1, mem_addr3, mem_wdata3;
    logic        mem_wr1, busy1, done1, exc1;
    logic        mem_wr3, busy3, done3, exc3;

    int checks = 0;
    int errors = 0;

    logic        busy_t [0:15];
    logic        wr_t   [0:15];
    logic [31:0] addr_t [0:15];
    logic [31:0] wdata_w, addr_w;
    int          wr_cnt, wr_cyc, done_cyc, exc_cyc;

    always #5 clk = ~clk;

    store_sequencer #(.MEM_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .store_size(store_size),
        .addr(addr), .store_data(store_data), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_wr(mem_wr1),
        .busy(busy1), .done(done1), .exc(exc1)
    );

    store_sequencer #(.MEM_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .start(start), .store_size(store_size),
        .addr(addr), .store_data(store_data), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_wr(mem_wr3),
        .busy(busy3), .done(done3), .exc(exc3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start, then traces cycles 1..ncyc of the selected instance.
    // poke re-requests with different operands during cycle 2 (WAIT).
    task automatic run(input bit sel3, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input int ncyc, input bit poke);
        logic w, dn, ex, bz;
        logic [31:0] ma, wd;
        store_size = sz;
        addr       = a;
        store_data = d;
        start      = 1'b1;
        tick();
        start    = 1'b0;
        wr_cnt   = 0;
        wr_cyc   = -1;
        done_cyc = -1;
        exc_cyc  = -1;
        wdata_w  = 32'hxxxxxxxx;
        addr_w   = 32'hxxxxxxxx;
        for (int c = 1; c <= ncyc; c++) begin
            w  = sel3 ? mem_wr3    : mem_wr1;
            dn = sel3 ? done3      : done1;
            ex = sel3 ? exc3       : exc1;
            bz = sel3 ? busy3      : busy1;
            ma = sel3 ? mem_addr3  : mem_addr1;
            wd = sel3 ? mem_wdata3 : mem_wdata1;
            busy_t[c] = bz;
            wr_t[c]   = w;
            addr_t[c] = ma;
            if (w) begin
                wr_cnt++;
                wr_cyc  = c;
                wdata_w = wd;
                addr_w  = ma;
            end
            if (dn && done_cyc < 0) done_cyc = c;
            if (ex && exc_cyc < 0)  exc_cyc  = c;
            if (poke && c == 2) begin
                start      = 1'b1;
                store_size = 2'b01;
                addr       = 32'h0000_0FF0;
                store_data = 32'h1234_5678;
            end
            if (poke && c == 3) start = 1'b0;
            tick();
        end
    endtask

    initial begin
        int wr_after;
        reset      = 1'b1;
        start      = 1'b0;
        store_size = 2'b00;
        addr       = 32'd0;
        store_data = 32'd0;
        mem_rdata  = 32'd0;
        tick();
        tick();
        chk("rst_busy",  {31'd0, busy1},  32'd0);
        chk("rst_done",  {31'd0, done1},  32'd0);
        chk("rst_exc",   {31'd0, exc1},   32'd0);
        chk("rst_wr",    {31'd0, mem_wr1}, 32'd0);
        chk("rst_addr",  mem_addr1,  32'd0);
        chk("rst_wdata", mem_wdata1, 32'd0);
        reset = 1'b0;
        tick();

        // Word store.
        run(1'b0, 2'b01, 32'h0000_0100, 32'hDEAD_BEEF, 5, 1'b0);
        chk("word_wr_cnt", wr_cnt, 1);
        chk("word_wr_cyc", wr_cyc, 1);
        chk("word_addr",   addr_w, 32'h0000_0100);
        chk("word_wdata",  wdata_w, 32'hDEAD_BEEF);
        chk("word_done",   done_cyc, 2);
        chk("word_idle3",  {31'd0, busy_t[3]}, 32'd0);

        // Half store, MEM_LAT=1.
        mem_rdata = 32'h1122_3344;
        run(1'b0, 2'b10, 32'h0000_0200, 32'hAAAA_5566, 6, 1'b0);
        chk("half_read_busy", {31'd0, busy_t[1]}, 32'd1);
        chk("half_read_nowr", {31'd0, wr_t[1]}, 32'd0);
        chk("half_read_addr", addr_t[1], 32'h0000_0200);
        chk("half_wr_cyc",    wr_cyc, 3);
        chk("half_wr_cnt",    wr_cnt, 1);
        chk("half_wdata",     wdata_w, 32'h1122_5566);
        chk("half_done",      done_cyc, 4);

        // Byte store, MEM_LAT=3, odd address.
        mem_rdata = 32'hCAFE_BABE;
        run(1'b1, 2'b11, 32'h0000_0303, 32'h0000_00F0, 8, 1'b0);
        chk("byte_wdata",  wdata_w, 32'hCAFE_BAF0);
        chk("byte_addr",   addr_w, 32'h0000_0303);
        chk("byte_wr_cyc", wr_cyc, 5);
        chk("byte_done",   done_cyc, 6);

        // Rejected requests.
        run(1'b0, 2'b01, 32'h0000_0102, 32'h1111_1111, 3, 1'b0);
        chk("exc_word_cyc", exc_cyc, 1);
        chk("exc_word_wr",  wr_cnt, 0);
        chk("exc_word_idle", {31'd0, busy_t[2]}, 32'd0);
        run(1'b0, 2'b10, 32'h0000_0101, 32'h2222_2222, 3, 1'b0);
        chk("exc_half_cyc", exc_cyc, 1);
        chk("exc_half_wr",  wr_cnt, 0);
        run(1'b0, 2'b00, 32'h0000_0100, 32'h3333_3333, 3, 1'b0);
        chk("exc_size0_cyc", exc_cyc, 1);
        chk("exc_size0_wr",  wr_cnt, 0);
        chk("exc_size0_done", done_cyc, -1);

        // Start and operand changes during WAIT are ignored.
        mem_rdata = 32'hCAFE_BABE;
        run(1'b1, 2'b10, 32'h0000_0400, 32'h0000_BEEF, 10, 1'b1);
        chk("busy_wr_cnt", wr_cnt, 1);
        chk("busy_addr",   addr_w, 32'h0000_0400);
        chk("busy_wdata",  wdata_w, 32'hCAFE_BEEF);
        chk("busy_done",   done_cyc, 6);

        // Reset during WAIT.
        store_size = 2'b10;
        addr       = 32'h0000_0500;
        store_data = 32'h0000_7777;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("mid_rst_wr",    {31'd0, mem_wr3}, 32'd0);
        chk("mid_rst_busy",  {31'd0, busy3},   32'd0);
        chk("mid_rst_done",  {31'd0, done3},   32'd0);
        chk("mid_rst_exc",   {31'd0, exc3},    32'd0);
        chk("mid_rst_addr",  mem_addr3,  32'd0);
        chk("mid_rst_wdata", mem_wdata3, 32'd0);
        reset    = 1'b0;
        wr_after = 0;
        for (int c = 0; c < 6; c++) begin
            if (mem_wr3) wr_after++;
            tick();
        end
        chk("mid_rst_nowr", wr_after, 0);

        run(1'b1, 2'b01, 32'h0000_0600, 32'h55AA_55AA, 5, 1'b0);
        chk("post_rst_wr_cyc", wr_cyc, 1);
        chk("post_rst_wdata",  wdata_w, 32'h55AA_55AA);
        chk("post_rst_done",   done_cyc, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
